// File: rtl/acc_multi_sequencer_pkg.sv
// acc_multi_pkg: shared types and constants for the accumulator sequencer.
// Decode bit positions, FSM states, string modes, STRNCPY length field.
package acc_multi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        GRANT,
        S_RD,
        S_WR,
        S_CHK,
        ERROR
    } state_t;

    typedef enum logic {
        CPY,
        NCPY
    } mode_t;

    localparam int DEC_LOAD        = 0;
    localparam int DEC_ADD         = 1;
    localparam int DEC_STORE       = 2;
    localparam int DEC_BRZ         = 3;
    localparam int DEC_STRCPY      = 4;
    localparam int DEC_CHK_STRCPY  = 5;
    localparam int DEC_STRNCPY     = 6;
    localparam int DEC_CHK_STRNCPY = 7;

    localparam int NLEN_LSB = 3;
    localparam int NLEN_MSB = 6;

    function automatic logic is_onehot(input logic [6:0] v);
        return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
    endfunction

endpackage

// File: rtl/acc_multi_sequencer_if.sv
// acc_multi_sequencer_if: single shared memory port, req/ack handshake.
// master = sequencer side, slave = memory side.
interface acc_multi_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/acc_multi_sequencer_mem_port.sv
// acc_mem_port_if: holds one memory request until ack (or timeout).
// Macro ACC_SEQ_MEM_TIMEOUT_EN adds the TIMEOUT-cycle ack watchdog.
module acc_mem_port_if
    import acc_multi_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    acc_multi_sequencer_if.master mem,
    input  logic                  launch,
    input  logic                  launch_we,
    input  logic [DATA_W-1:0]     launch_addr,
    input  logic [DATA_W-1:0]     launch_wdata,
    output logic                  done,
    output logic                  tmo,
    output logic [DATA_W-1:0]     rdata
);

    assign done  = mem.mem_req & mem.mem_ack;
    assign rdata = mem.mem_rdata;

    // Request register: a new launch wins over completing the old one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else if (launch) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= launch_we;
            mem.mem_addr  <= launch_addr;
            mem.mem_wdata <= launch_wdata;
        end else if (done || tmo) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
        end
    end

`ifdef ACC_SEQ_MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Cycles spent waiting on the current request.
    always_ff @(posedge clk) begin
        if (!rst || launch || done) begin
            cnt <= '0;
        end else if (mem.mem_req) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tmo = mem.mem_req && !mem.mem_ack
              && (cnt == CW'(TIMEOUT - 1));
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT > 0);
    assign tmo        = 1'b0;
`endif

endmodule

// File: rtl/acc_multi_sequencer.sv
// acc_multi_sequencer: accumulator ISA controller, STRCPY/STRNCPY sequencer.
// Optional macro ACC_SEQ_MEM_TIMEOUT_EN: memory ack timeout to ERROR.
module acc_multi_sequencer
    import acc_multi_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int MAX_STR = 256,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  halt,
    input  logic [7:0]            acc_decode,
    input  logic [15:0]           instr,
    input  logic [DATA_W-1:0]     src_base,
    input  logic [DATA_W-1:0]     dst_base,
    output logic [7:0]            grant,
    output logic                  strcpy_step,
    output logic                  strncpy_step,
    output logic [DATA_W-1:0]     curr_char,
    output logic [DATA_W-1:0]     index,
    output logic                  busy,
    output logic                  err,
    acc_multi_sequencer_if.master mem
);

    state_t            state;
    mode_t             mode;
    logic [3:0]        nlen;
    logic [6:0]        dec;
    logic [3:0]        nlen_in;
    logic              dec_ok;
    logic              start_str;
    logic              chk_stop;
    logic [DATA_W-1:0] last_idx;
    logic              launch;
    logic              launch_we;
    logic [DATA_W-1:0] launch_addr;
    logic [DATA_W-1:0] launch_wdata;
    logic              done;
    logic              tmo;
    logic [DATA_W-1:0] rdata;
    logic              unused_bits;

    assign dec       = acc_decode[6:0];
    assign nlen_in   = instr[NLEN_MSB:NLEN_LSB];
    assign dec_ok    = is_onehot(dec);
    assign start_str = dec_ok && (dec[DEC_STRCPY]
                    || (dec[DEC_STRNCPY] && nlen_in != 4'd0));
    assign last_idx  = DATA_W'(nlen) - DATA_W'(1);
    assign chk_stop  = (mode == CPY)
                     ? (curr_char == '0
                        || index == DATA_W'(MAX_STR - 1))
                     : (index == last_idx);
    assign busy      = (state != IDLE);

    assign unused_bits = ^{acc_decode[7], instr[15:7], instr[2:0]};

    // Next memory request, issued on entry to S_RD / S_WR.
    always_comb begin
        launch       = 1'b0;
        launch_we    = 1'b0;
        launch_addr  = src_base;
        launch_wdata = curr_char;
        unique case (state)
            DECODE: launch = !halt && start_str;
            S_RD: begin
                launch       = done;
                launch_we    = 1'b1;
                launch_addr  = dst_base + index;
                launch_wdata = rdata;
            end
            S_CHK: begin
                launch      = !chk_stop;
                launch_addr = src_base + index + 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer FSM; grant and step outputs are one-cycle pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            mode         <= CPY;
            nlen         <= '0;
            grant        <= '0;
            strcpy_step  <= 1'b0;
            strncpy_step <= 1'b0;
            curr_char    <= '0;
            index        <= '0;
            err          <= 1'b0;
        end else begin
            grant        <= '0;
            strcpy_step  <= 1'b0;
            strncpy_step <= 1'b0;
            unique case (state)
                IDLE: if (start) state <= DECODE;
                DECODE: begin
                    if (halt) begin
                        state <= IDLE;
                    end else if (!dec_ok) begin
                        state <= ERROR;
                        err   <= 1'b1;
                    end else begin
                        unique case (1'b1)
                            dec[DEC_STRCPY]: begin
                                index <= '0;
                                mode  <= CPY;
                                state <= S_RD;
                            end
                            dec[DEC_STRNCPY]: begin
                                if (nlen_in == 4'd0) begin
                                    state <= ERROR;
                                    err   <= 1'b1;
                                end else begin
                                    nlen  <= nlen_in;
                                    index <= '0;
                                    mode  <= NCPY;
                                    state <= S_RD;
                                end
                            end
                            dec[DEC_CHK_STRCPY]: begin
                                state <= ERROR;
                                err   <= 1'b1;
                            end
                            default: begin
                                grant <= {4'b0, dec[3:0]};
                                state <= GRANT;
                            end
                        endcase
                    end
                end
                GRANT: state <= DECODE;
                S_RD: begin
                    if (tmo) begin
                        state <= ERROR;
                        err   <= 1'b1;
                    end else if (done) begin
                        curr_char <= rdata;
                        state     <= S_WR;
                    end
                end
                S_WR: begin
                    if (tmo) begin
                        state <= ERROR;
                        err   <= 1'b1;
                    end else if (done) begin
                        state <= S_CHK;
                        if (mode == CPY) begin
                            strcpy_step           <= 1'b1;
                            grant[DEC_CHK_STRCPY] <= 1'b1;
                        end else begin
                            strncpy_step           <= 1'b1;
                            grant[DEC_CHK_STRNCPY] <= 1'b1;
                        end
                    end
                end
                S_CHK: begin
                    if (!chk_stop) begin
                        index <= index + 1'b1;
                        state <= S_RD;
                    end else if (mode == CPY && curr_char != '0) begin
                        state <= ERROR;
                        err   <= 1'b1;
                    end else begin
                        state <= DECODE;
                    end
                end
                ERROR: err <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

    acc_mem_port_if #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_port (
        .clk          (clk),
        .rst          (rst),
        .mem          (mem),
        .launch       (launch),
        .launch_we    (launch_we),
        .launch_addr  (launch_addr),
        .launch_wdata (launch_wdata),
        .done         (done),
        .tmo          (tmo),
        .rdata        (rdata)
    );

endmodule

// File: tb/tb_acc_multi_sequencer.sv
// tb_acc_multi_sequencer: randomized bench with a string-copy reference model.
// Build with ACC_SEQ_MEM_TIMEOUT_EN to also exercise the ack timeout.
module tb_acc_multi_sequencer;

    localparam int MAX_STR = 256;

    logic        clk;
    logic        rst;
    logic        start;
    logic        halt;
    logic [7:0]  acc_decode;
    logic [15:0] instr;
    logic [15:0] src_base;
    logic [15:0] dst_base;
    logic [7:0]  grant;
    logic        strcpy_step;
    logic        strncpy_step;
    logic [15:0] curr_char;
    logic [15:0] index;
    logic        busy;
    logic        err;

    acc_multi_sequencer_if #(.DATA_W(16)) mif();

    acc_multi_sequencer #(
        .DATA_W  (16),
        .MAX_STR (MAX_STR),
        .TIMEOUT (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .halt         (halt),
        .acc_decode   (acc_decode),
        .instr        (instr),
        .src_base     (src_base),
        .dst_base     (dst_base),
        .grant        (grant),
        .strcpy_step  (strcpy_step),
        .strncpy_step (strncpy_step),
        .curr_char    (curr_char),
        .index        (index),
        .busy         (busy),
        .err          (err),
        .mem          (mif)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] ram [0:65535];
    logic [32:0] txq [$];
    logic [32:0] exp_tx [$];
    logic [41:0] stq [$];
    logic [41:0] exp_st [$];
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          no_ack = 0;
    int          wcnt = 0;
    int          tgt = 1;
    int          req_cnt = 0;
    int          bad_grant = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Memory model: ack after a random wait, one access per ack.
    always @(negedge clk) begin
        if (mif.mem_req) req_cnt <= req_cnt + 1;
        if (mif.mem_ack) begin
            mif.mem_ack <= 1'b0;
            wcnt        <= 0;
            tgt         <= $urandom_range(lat_hi, lat_lo);
        end else if (!mif.mem_req) begin
            mif.mem_ack <= 1'b0;
            wcnt        <= 0;
            tgt         <= $urandom_range(lat_hi, lat_lo);
        end else if (!no_ack) begin
            if (wcnt >= tgt) begin
                mif.mem_ack <= 1'b1;
                if (mif.mem_we) begin
                    ram[mif.mem_addr] <= mif.mem_wdata;
                    txq.push_back({1'b1, mif.mem_addr, mif.mem_wdata});
                end else begin
                    mif.mem_rdata <= ram[mif.mem_addr];
                    txq.push_back({1'b0, mif.mem_addr, ram[mif.mem_addr]});
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    // Step-pulse monitor and grant one-hot watch.
    always @(negedge clk) begin
        if (grant[5] || grant[7])
            stq.push_back({grant, strcpy_step, strncpy_step, index, curr_char});
        if (rst && !$onehot0(grant)) bad_grant <= bad_grant + 1;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    // Reference: what a string copy must do, one character at a time.
    task automatic model(input bit ncpy, input logic [15:0] src,
                         input logic [15:0] dst, input int n,
                         output bit e);
        logic [15:0] c;
        logic [15:0] i;
        e = 1'b0;
        for (int k = 0; k < 70000; k++) begin
            i = 16'(k);
            c = ram[src + i];
            exp_tx.push_back({1'b0, 16'(src + i), c});
            exp_tx.push_back({1'b1, 16'(dst + i), c});
            if (ncpy) exp_st.push_back({8'h80, 2'b01, i, c});
            else      exp_st.push_back({8'h20, 2'b10, i, c});
            if (ncpy) begin
                if (k == n - 1) break;
            end else if (c == 16'h0) begin
                break;
            end else if (k == MAX_STR - 1) begin
                e = 1'b1;
                break;
            end
        end
    endtask

    task automatic compare_logs(input string tag);
        check({tag, ":ntx"}, 64'(txq.size()), 64'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < txq.size(); i++)
            check($sformatf("%s:tx%0d", tag, i), 64'(txq[i]), 64'(exp_tx[i]));
        check({tag, ":nstep"}, 64'(stq.size()), 64'(exp_st.size()));
        for (int i = 0; i < exp_st.size() && i < stq.size(); i++)
            check($sformatf("%s:st%0d", tag, i), 64'(stq[i]), 64'(exp_st[i]));
    endtask

    task automatic put_str(input logic [15:0] a, input string s);
        for (int i = 0; i < s.len(); i++) ram[16'(a + 16'(i))] = {8'h00, s[i]};
    endtask

    task automatic run_str(input string tag, input bit ncpy,
                           input logic [15:0] src, input logic [15:0] dst,
                           input int n);
        bit e;
        int cyc;
        txq.delete();
        stq.delete();
        exp_tx.delete();
        exp_st.delete();
        model(ncpy, src, dst, n, e);
        acc_decode  = ncpy ? 8'h40 : 8'h10;
        instr       = 16'($urandom);
        instr[6:3]  = 4'(n);
        src_base    = src;
        dst_base    = dst;
        start       = 1'b1;
        step();
        start       = 1'b0;
        step();
        acc_decode  = 8'h00;
        halt        = 1'b1;
        cyc = 0;
        while (busy && !err && cyc < 8000) begin
            step();
            cyc++;
        end
        halt = 1'b0;
        check({tag, ":bounded"}, 64'(cyc < 8000), 64'd1);
        check({tag, ":err"}, 64'(err), 64'(e));
        compare_logs(tag);
        if (err) begin
            step();
            check({tag, ":err_grant"}, 64'(grant), 64'h0);
            check({tag, ":err_req"}, 64'(mif.mem_req), 64'h0);
            do_reset();
        end
    endtask

    task automatic err_case(input string tag, input logic [7:0] d,
                            input logic [15:0] ins);
        acc_decode = d;
        instr      = ins;
        start      = 1'b1;
        step();
        start      = 1'b0;
        step();
        check({tag, ":err"}, 64'(err), 64'h1);
        check({tag, ":busy"}, 64'(busy), 64'h1);
        acc_decode = 8'h02;
        start      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check({tag, ":grant0"}, 64'(grant), 64'h0);
        end
        check({tag, ":held"}, 64'(err), 64'h1);
        check({tag, ":noreq"}, 64'(mif.mem_req), 64'h0);
        start = 1'b0;
        do_reset();
        check({tag, ":cleared"}, 64'(err), 64'h0);
    endtask

    initial begin
        int          cyc;
        int          r0;
        int          n;
        logic [7:0]  expg;
        logic [15:0] s;
        logic [15:0] d;

        rst        = 1'b0;
        start      = 1'b0;
        halt       = 1'b0;
        acc_decode = 8'h00;
        instr      = 16'h0;
        src_base   = 16'h0;
        dst_base   = 16'h0;
        step();
        step();
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_req", 64'(mif.mem_req), 64'h0);
        check("rst_index", 64'(index), 64'h0);
        check("rst_char", 64'(curr_char), 64'h0);
        check("rst_steps", 64'({strcpy_step, strncpy_step}), 64'h0);
        rst = 1'b1;
        step();
        check("idle_busy", 64'(busy), 64'h0);

        r0         = req_cnt;
        acc_decode = 8'h02;
        start      = 1'b1;
        step();
        start      = 1'b0;
        check("dec_busy", 64'(busy), 64'h1);
        check("dec_grant", 64'(grant), 64'h0);
        for (int k = 0; k < 10; k++) begin
            expg = acc_decode;
            step();
            check($sformatf("grant%0d", k), 64'(grant), 64'(expg));
            acc_decode = 8'h01 << $urandom_range(3, 0);
            step();
            check($sformatf("grant_off%0d", k), 64'(grant), 64'h0);
        end
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("halt_idle", 64'(busy), 64'h0);
        check("grant_noreq", 64'(req_cnt - r0), 64'h0);

        put_str(16'h0040, "AB");
        ram[16'h0042] = 16'h0000;
        run_str("cpy_ab", 1'b0, 16'h0040, 16'h0080, 0);
        check("cpy_ab_n", 64'(stq.size()), 64'd3);
        if (stq.size() == 3)
            check("cpy_ab_last", 64'(stq[2][15:0]), 64'h0);
        check("cpy_ab_dst", 64'(ram[16'h0081]), 64'h42);

        put_str(16'h0100, "A Z");
        ram[16'h0101] = 16'h0000;
        run_str("ncpy3", 1'b1, 16'h0100, 16'h0180, 3);
        if (stq.size() == 3)
            check("ncpy3_idx", 64'(stq[2][31:16]), 64'h2);

        err_case("ncpy0", 8'h40, 16'h0000);
        err_case("dec03", 8'h03, 16'h0000);
        err_case("dec00", 8'h00, 16'h0000);

        put_str(16'hFFFE, "wrap");
        ram[16'h0002] = 16'h0000;
        run_str("wrap", 1'b0, 16'hFFFE, 16'h5000, 0);

        lat_lo = 0;
        lat_hi = 0;
        for (int i = 0; i < MAX_STR; i++)
            ram[16'h3000 + 16'(i)] = 16'(1 + (i % 200));
        run_str("maxstr", 1'b0, 16'h3000, 16'h4000, 0);

        lat_lo = 0;
        lat_hi = 3;
        for (int k = 0; k < 8; k++) begin
            s = 16'h1000 + 16'(k * 64);
            d = 16'h2000 + 16'(k * 64);
            n = $urandom_range(15, 1);
            if (k[0]) begin
                for (int i = 0; i < n; i++)
                    ram[s + 16'(i)] = 16'($urandom_range(3, 0) == 0
                                    ? 0 : $urandom_range(255, 1));
                run_str($sformatf("rncpy%0d", k), 1'b1, s, d, n);
            end else begin
                for (int i = 0; i < n; i++)
                    ram[s + 16'(i)] = 16'($urandom_range(255, 1));
                ram[s + 16'(n)] = 16'h0000;
                run_str($sformatf("rcpy%0d", k), 1'b0, s, d, 0);
            end
        end

        lat_lo = 6;
        lat_hi = 6;
        put_str(16'h6000, "XYZ");
        ram[16'h6003] = 16'h0000;
        acc_decode = 8'h10;
        src_base   = 16'h6000;
        dst_base   = 16'h6100;
        start      = 1'b1;
        step();
        start      = 1'b0;
        step();
        acc_decode = 8'h00;
        cyc = 0;
        while (!(mif.mem_req && mif.mem_we && index == 16'h1) && cyc < 200) begin
            step();
            cyc++;
        end
        check("mid_wr_found", 64'(cyc < 200), 64'd1);
        step();
        rst = 1'b0;
        step();
        check("mid_rst_req", 64'(mif.mem_req), 64'h0);
        check("mid_rst_index", 64'(index), 64'h0);
        check("mid_rst_busy", 64'(busy), 64'h0);
        check("mid_rst_char", 64'(curr_char), 64'h0);
        rst = 1'b1;
        step();
        check("mid_rst_idle", 64'({busy, mif.mem_req}), 64'h0);
        lat_lo = 1;
        lat_hi = 1;

`ifdef ACC_SEQ_MEM_TIMEOUT_EN
        no_ack     = 1'b1;
        put_str(16'h7000, "Q");
        acc_decode = 8'h10;
        src_base   = 16'h7000;
        dst_base   = 16'h7100;
        start      = 1'b1;
        step();
        start      = 1'b0;
        step();
        acc_decode = 8'h00;
        check("tmo_req", 64'(mif.mem_req), 64'h1);
        cyc = 0;
        while (!err && cyc < 200) begin
            step();
            cyc++;
        end
        check("tmo_cycles", 64'(cyc), 64'd64);
        check("tmo_req_drop", 64'(mif.mem_req), 64'h0);
        do_reset();
        no_ack = 1'b0;
`endif

        step();
        check("grant_onehot", 64'(bad_grant), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
